alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue stage that sits directly upstream of the 8-bit accumulator ALU. It accepts 16-bit instructions over a valid/ready handshake and holds a 4×8 register file. For each instruction it drives the ALU's A, B and CTR inputs from registers, waits out the ALU's two-register latency, and writes the ALU output back to the destination register. Instructions are strictly serialized, so there are no hazards.

## Interface
Parameters:
- NREG, 4: register-file depth (fixed at 4; register index is 2 bits).
- W, 8: datapath width; must match the ALU.

Ports:
- ck  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_instr  in  16  instruction; see Operation.
- alu_a  out  8  registered operand A to ALU.
- alu_b  out  8  registered operand B to ALU.
- alu_ctr  out  4  registered op code to ALU.
- alu_o  in  8  ALU result input.
- wb_valid  out  1  one-cycle pulse: a register was written.
- wb_dst  out  2  register written.
- wb_data  out  8  value written.
- rd_sel  in  2  debug read select.
- rd_data  out  8  combinational read of regfile[rd_sel].
- err  out  1  sticky; illegal op code seen.

## Operation
Instruction fields:
- [15] li: 1 = load immediate, 0 = ALU op.
- [14:11] ctr.
- [10:9] dst.
- [8:7] sa.
- [6:5] sb.
- [7:0] imm (li only).
- Unused bits are ignored.

Legal ctr codes:
- 0000 add, 0001 sub, 1000 and, 1001 or, 1010 xor.
- 1100 shr1, 1101 shl1, 1110 rotr1, 1111 rotl1.
- 1011 is illegal.
- Any other code is legal and yields 0 from the ALU; the sequencer writes that 0 back.

FSM states: IDLE, S1, S2, S3.

IDLE, accept (in_valid && in_ready):
- li=1: regfile[dst] <= imm; wb pulse with dst/imm; stay IDLE.
- li=0, ctr=1011: err <= 1; no ALU issue, no writeback; stay IDLE.
- li=0, other ctr: alu_a <= regfile[sa]; alu_b <= regfile[sb]; alu_ctr <= ctr; latch dst; go to S1.

Other states:
- S1 -> S2 -> S3 unconditionally.
- S3: regfile[dst] <= alu_o; wb pulse; go to IDLE.

General rules:
- sa == sb is allowed; so is dst == sa or sb. Operands are read before writeback.
- alu_* hold their values outside accept edges.
- Arithmetic is the ALU's, modulo 2^8; the sequencer does no arithmetic.

## Timing
- Accept at edge E0. The ALU captures operands at E1 (acc) and updates its output at E2. The sequencer samples alu_o and writes the register at E3.
- wb_valid is high during the cycle after E3. Next accept is no earlier than E4.
- ALU op throughput: one per 4 cycles. li: one per cycle; back-to-back li to the same dst means the last one wins.
- An instruction accepted right after a writeback reads the updated value.
- in_ready is a registered decode of state; it is low in S1–S3. The offered instruction must be held stable until accepted.
- wb_valid, wb_dst and wb_data are registered. wb_dst/wb_data hold their last values when wb_valid is low.

Reset (rst at any edge, including mid-operation):
- Values: state IDLE, every regfile entry 0, alu_a/alu_b/alu_ctr 0, wb_valid 0, wb_dst 0, wb_data 0, err 0.
- An in-flight ALU op is abandoned and never written back. The ALU itself has no reset; its stale output is ignored.

## Structure
- Package alu_pkg holds:
  - CTR code constants (ADD, SUB, AND, OR, XOR, ILL=1011, SHR, SHL, ROTR, ROTL).
  - Instruction field bit positions.
  - FSM state encoding.
- Sub-module regfile4x8: one synchronous write port, two read ports for operands, one debug read port, synchronous reset to zero.
- Top level holds the FSM, operand/ctr registers, dst latch, writeback outputs and err.

## Test plan
- Reset, then li r0=0x35, li r1=0x0C, add r2=r0+r1 -> wb pulses r0/0x35, r1/0x0C, then r2/0x41 exactly 4 cycles after the add is accepted; in_ready is low for 3 cycles.
- li r0=0x03, sub r1=r0-r0, then sub r2=r1-r0 -> r1=0x00, r2=0xFD (wrap).
- li r3=0x81, rotl1 r3=r3, then rotr1 r0=r3 -> r3=0x03, r0=0x81; shl1 on 0x81 -> 0x02; shr1 -> 0x40.
- Op with ctr=1011 -> err goes high and stays high, no wb pulse, in_ready stays high; a following add still completes correctly.
- Assert rst in S2 of an add to r1 -> no writeback, all registers 0, in_ready high the next cycle, rd_data(r1)=0.
- in_valid held high with a stream of 3 ALU ops -> each accepted only in IDLE, in_ready pattern 1000 repeating, results match a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes, instruction layout, FSM states.
package alu_pkg;

  localparam logic [3:0] CTR_ADD  = 4'b0000;
  localparam logic [3:0] CTR_SUB  = 4'b0001;
  localparam logic [3:0] CTR_AND  = 4'b1000;
  localparam logic [3:0] CTR_OR   = 4'b1001;
  localparam logic [3:0] CTR_XOR  = 4'b1010;
  localparam logic [3:0] CTR_ILL  = 4'b1011;
  localparam logic [3:0] CTR_SHR  = 4'b1100;
  localparam logic [3:0] CTR_SHL  = 4'b1101;
  localparam logic [3:0] CTR_ROTR = 4'b1110;
  localparam logic [3:0] CTR_ROTL = 4'b1111;

  // imm overlaps sa/sb; it is only meaningful when li is set
  localparam int INSTR_LI = 15;
  localparam int CTR_MSB  = 14;
  localparam int CTR_LSB  = 11;
  localparam int DST_MSB  = 10;
  localparam int DST_LSB  = 9;
  localparam int SA_MSB   = 8;
  localparam int SA_LSB   = 7;
  localparam int SB_MSB   = 6;
  localparam int SB_LSB   = 5;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_t;

endpackage

// File: rtl/regfile4x8.sv
// Small register file: one write port, two operand read ports and a debug read port.
module regfile4x8 #(
  parameter int NREG = 4,
  parameter int W    = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra_sel,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_sel,
  output logic [W-1:0]  rb_data,
  input  logic [AW-1:0] dbg_sel,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] mem_reg [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_row
      always_ff @(posedge ck) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (we && waddr == AW'(gi))
          mem_reg[gi] <= wdata;
      end
    end
  endgenerate

  // Reads are combinational so an op accepted right after a write sees the new value
  assign ra_data  = mem_reg[ra_sel];
  assign rb_data  = mem_reg[rb_sel];
  assign dbg_data = mem_reg[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Serializing issue stage for the two-register-latency accumulator ALU.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_instr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctr,
  input  logic [W-1:0] alu_o,
  output logic         wb_valid,
  output logic [1:0]   wb_dst,
  output logic [W-1:0] wb_data,
  input  logic [1:0]   rd_sel,
  output logic [W-1:0] rd_data,
  output logic         err
);

  state_t state_reg, state_next;
  logic [1:0]   dst_reg;
  logic         accept;
  logic         f_li;
  logic [3:0]   f_ctr;
  logic [1:0]   f_dst, f_sa, f_sb;
  logic [W-1:0] f_imm;
  logic [W-1:0] opa_data, opb_data;
  logic         rf_we;
  logic [1:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic         issue, set_err;

  assign f_li   = in_instr[INSTR_LI];
  assign f_ctr  = in_instr[CTR_MSB:CTR_LSB];
  assign f_dst  = in_instr[DST_MSB:DST_LSB];
  assign f_sa   = in_instr[SA_MSB:SA_LSB];
  assign f_sb   = in_instr[SB_MSB:SB_LSB];
  assign f_imm  = in_instr[IMM_MSB:IMM_LSB];
  assign accept = in_valid && in_ready;

  regfile4x8 #(.NREG(NREG), .W(W)) u_rf (
    .ck       (ck),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_sel   (f_sa),
    .ra_data  (opa_data),
    .rb_sel   (f_sb),
    .rb_data  (opb_data),
    .dbg_sel  (rd_sel),
    .dbg_data (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    rf_we      = 1'b0;
    rf_waddr   = f_dst;
    rf_wdata   = f_imm;
    issue      = 1'b0;
    set_err    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (f_li)
            rf_we = 1'b1;
          else if (f_ctr == CTR_ILL)
            set_err = 1'b1;
          else begin
            issue      = 1'b1;
            state_next = ST_S1;
          end
        end
      end
      ST_S1: state_next = ST_S2;
      ST_S2: state_next = ST_S3;
      // alu_o now reflects the operands issued three edges ago
      ST_S3: begin
        rf_we      = 1'b1;
        rf_waddr   = dst_reg;
        rf_wdata   = alu_o;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      in_ready  <= 1'b1;
      dst_reg   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctr   <= '0;
      wb_valid  <= 1'b0;
      wb_dst    <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      in_ready  <= (state_next == ST_IDLE);
      wb_valid  <= rf_we;
      if (rf_we) begin
        wb_dst  <= rf_waddr;
        wb_data <= rf_wdata;
      end
      if (issue) begin
        alu_a   <= opa_data;
        alu_b   <= opb_data;
        alu_ctr <= f_ctr;
        dst_reg <= f_dst;
      end
      if (set_err)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural two-register-latency ALU attached.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  alu_a, alu_b, alu_o;
  logic [3:0]  alu_ctr;
  logic        wb_valid;
  logic [1:0]  wb_dst;
  logic [7:0]  wb_data;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.NREG(4), .W(8)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .err(err)
  );

  always #5 ck = ~ck;

  // ALU stand-in: operand register at the first edge, output register at the second
  logic [7:0] acc_a = '0, acc_b = '0;
  logic [3:0] acc_ctr = '0;
  initial alu_o = '0;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    case (c)
      CTR_ADD:  return a + b;
      CTR_SUB:  return a - b;
      CTR_AND:  return a & b;
      CTR_OR:   return a | b;
      CTR_XOR:  return a ^ b;
      CTR_SHR:  return {1'b0, a[7:1]};
      CTR_SHL:  return {a[6:0], 1'b0};
      CTR_ROTR: return {a[0], a[7:1]};
      CTR_ROTL: return {a[6:0], a[7]};
      default:  return 8'h00;
    endcase
  endfunction

  always @(posedge ck) begin
    acc_a   <= alu_a;
    acc_b   <= alu_b;
    acc_ctr <= alu_ctr;
    alu_o   <= alu_f(acc_a, acc_b, acc_ctr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [15:0] mk_li(input logic [1:0] dst, input logic [7:0] imm);
    return {1'b1, 4'b0000, dst, 1'b0, imm};
  endfunction

  function automatic logic [15:0] mk_op(input logic [3:0] c, input logic [1:0] dst,
                                        input logic [1:0] sa, input logic [1:0] sb);
    return {1'b0, c, dst, sa, sb, 5'b00000};
  endfunction

  task automatic do_li(input logic [1:0] dst, input logic [7:0] imm);
    check_eq("li_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_instr = mk_li(dst, imm);
    tick();
    in_valid = 1'b0;
    check_eq("li_wb_valid", wb_valid, 1'b1);
    check_eq("li_wb_dst", wb_dst, dst);
    check_eq("li_wb_data", wb_data, imm);
    $display("li   r%0d = %02h : wb r%0d %02h", dst, imm, wb_dst, wb_data);
  endtask

  task automatic do_op(input string name, input logic [3:0] c, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] exp);
    check_eq({name, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_instr = mk_op(c, dst, sa, sb);
    tick();
    in_valid = 1'b0;
    check_eq({name, "_ctr"}, alu_ctr, c);
    for (int i = 0; i < 3; i++) begin
      check_eq({name, "_busy"}, in_ready, 1'b0);
      check_eq({name, "_no_wb"}, wb_valid, 1'b0);
      tick();
    end
    check_eq({name, "_wb_valid"}, wb_valid, 1'b1);
    check_eq({name, "_wb_dst"}, wb_dst, dst);
    check_eq({name, "_wb_data"}, wb_data, exp);
    check_eq({name, "_ready_back"}, in_ready, 1'b1);
    rd_sel = dst;
    #1;
    check_eq({name, "_rd"}, rd_data, exp);
    $display("%-5s r%0d = r%0d,r%0d : wb r%0d %02h (want %02h)", name, dst, sa, sb, wb_dst, wb_data, exp);
  endtask

  localparam logic [7:0] STREAM_EXP [3] = '{8'h11, 8'h12, 8'h03};

  initial begin
    logic [15:0] stream [3];
    int idx;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; rd_sel = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_wb_dst", wb_dst, 2'd0);
    check_eq("rst_wb_data", wb_data, 8'h00);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_alu", {alu_a, alu_b, alu_ctr}, 20'h0);
    for (int r = 0; r < 4; r++) begin
      rd_sel = r[1:0];
      #1;
      check_eq("rst_rf", rd_data, 8'h00);
    end
    $display("reset: ready=%0b err=%0b", in_ready, err);

    // basic add, back-to-back li
    do_li(2'd0, 8'h35);
    do_li(2'd1, 8'h0C);
    do_op("add", CTR_ADD, 2'd2, 2'd0, 2'd1, 8'h41);

    // subtraction with wrap, sa == sb, dst == source
    do_li(2'd0, 8'h03);
    do_op("sub", CTR_SUB, 2'd1, 2'd0, 2'd0, 8'h00);
    do_op("sub", CTR_SUB, 2'd2, 2'd1, 2'd0, 8'hFD);

    // rotates and shifts on 0x81
    do_li(2'd3, 8'h81);
    do_op("rotl", CTR_ROTL, 2'd3, 2'd3, 2'd3, 8'h03);
    do_op("rotr", CTR_ROTR, 2'd0, 2'd3, 2'd3, 8'h81);
    do_op("shl", CTR_SHL, 2'd1, 2'd0, 2'd0, 8'h02);
    do_op("shr", CTR_SHR, 2'd2, 2'd0, 2'd0, 8'h40);

    // illegal op: sticky err, no writeback, stays ready
    in_valid = 1'b1;
    in_instr = mk_op(CTR_ILL, 2'd3, 2'd0, 2'd1);
    tick();
    in_valid = 1'b0;
    check_eq("ill_err", err, 1'b1);
    check_eq("ill_no_wb", wb_valid, 1'b0);
    check_eq("ill_ready", in_ready, 1'b1);
    tick();
    check_eq("ill_err_sticky", err, 1'b1);
    $display("ill  ctr=1011 : err=%0b wb_valid=%0b ready=%0b", err, wb_valid, in_ready);
    do_op("add", CTR_ADD, 2'd3, 2'd1, 2'd2, 8'h42);
    check_eq("ill_err_hold", err, 1'b1);
    do_op("c0010", 4'b0010, 2'd3, 2'd0, 2'd0, 8'h00);

    // reset while in S2 abandons the op
    do_li(2'd1, 8'h77);
    in_valid = 1'b1;
    in_instr = mk_op(CTR_ADD, 2'd1, 2'd1, 2'd1);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_ready", in_ready, 1'b1);
    check_eq("mid_rst_no_wb", wb_valid, 1'b0);
    check_eq("mid_rst_err", err, 1'b0);
    rd_sel = 2'd1;
    #1;
    check_eq("mid_rst_r1", rd_data, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid_rst_quiet", wb_valid, 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      rd_sel = r[1:0];
      #1;
      check_eq("mid_rst_rf", rd_data, 8'h00);
    end
    $display("rst in S2: ready=%0b wb_valid=%0b r1=%02h", in_ready, wb_valid, rd_data);

    // in_valid held high over a stream of dependent ALU ops
    do_li(2'd0, 8'h10);
    do_li(2'd1, 8'h01);
    stream[0] = mk_op(CTR_ADD, 2'd2, 2'd0, 2'd1);
    stream[1] = mk_op(CTR_ADD, 2'd3, 2'd2, 2'd1);
    stream[2] = mk_op(CTR_XOR, 2'd0, 2'd3, 2'd2);
    idx = 0;
    in_valid = 1'b1;
    in_instr = stream[0];
    for (int c = 0; c < 12; c++) begin
      check_eq("stream_ready", in_ready, (c % 4) == 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_instr = stream[idx];
        else in_valid = 1'b0;
      end
      check_eq("stream_wb_valid", wb_valid, (c % 4) == 3);
      if ((c % 4) == 3) begin
        check_eq("stream_wb_data", wb_data, STREAM_EXP[c / 4]);
        $display("stream op%0d : wb r%0d %02h (want %02h)", c / 4, wb_dst, wb_data, STREAM_EXP[c / 4]);
      end
    end
    in_valid = 1'b0;
    rd_sel = 2'd0;
    #1;
    check_eq("stream_r0", rd_data, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
